pc_gen: RTL and testbench

Parametrised program-counter generator for the fetch stage. It holds the current instruction address and selects the next one from reset, sequential, jump, call/return and trap sources. It adds a circular return-address stack (RAS), an exception PC register, target-misalignment detection and a fetch stall. It feeds the instruction-memory address and the link value used by the register file on calls.

---
 rtl/pc_gen.sv | 129 ++++++++++++
 tb/tb_pc_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch-stage program counter: selects the next instruction address from reset,
// sequential, jump, call/return (circular RAS) and trap sources, with misalign and underflow traps.
module pc_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h100),
    parameter int              RAS_DEPTH = 4,
    parameter int              ALIGN     = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [2:0]      sel,
    input  logic [XLEN-1:0] jump_dir,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_inc,
    output logic [XLEN-1:0] epc_out,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            misalign,
    output logic            ras_underflow
);

    localparam int              PTR_W      = $clog2(RAS_DEPTH);
    localparam int              CNT_W      = $clog2(RAS_DEPTH + 1);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN) - 64'd1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;
    logic [PTR_W-1:0] ras_ptr_m1;
    logic [CNT_W-1:0] ras_cnt;
    logic [XLEN-1:0]  epc;
    logic [XLEN-1:0]  ras_top;
    logic             jump_bad;
    logic             top_bad;
    logic             epc_bad;
    logic             push_en;

    assign pc_inc     = pc_out + XLEN'(4);
    assign epc_out    = epc;
    assign ras_empty  = (ras_cnt == '0);
    assign ras_full   = (ras_cnt == CNT_MAX);
    assign ras_ptr_m1 = ras_ptr - PTR_W'(1);
    assign ras_top    = ras_mem[ras_ptr_m1];
    assign jump_bad   = (jump_dir & ALIGN_MASK) != '0;
    assign top_bad    = (ras_top & ALIGN_MASK) != '0;
    assign epc_bad    = (epc & ALIGN_MASK) != '0;
    assign push_en    = !rst && !stall && (sel == 3'd4) && !jump_bad;

    // RAS contents are not reset; only the pointer and count define validity.
    always_ff @(posedge clk) begin
        if (push_en)
            ras_mem[ras_ptr] <= pc_inc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out        <= RESET_VEC;
            epc           <= '0;
            ras_ptr       <= '0;
            ras_cnt       <= '0;
            misalign      <= 1'b0;
            ras_underflow <= 1'b0;
        end else if (stall) begin
            misalign      <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            misalign      <= 1'b0;
            ras_underflow <= 1'b0;
            case (sel)
                3'd0: pc_out <= RESET_VEC;
                3'd1: begin
                    if (jump_bad) begin
                        pc_out   <= TRAP_VEC;
                        epc      <= pc_out;
                        misalign <= 1'b1;
                    end else begin
                        pc_out <= jump_dir;
                    end
                end
                3'd2: pc_out <= pc_inc;
                3'd3: pc_out <= pc_out;
                3'd4: begin
                    if (jump_bad) begin
                        pc_out   <= TRAP_VEC;
                        epc      <= pc_out;
                        misalign <= 1'b1;
                    end else begin
                        pc_out  <= jump_dir;
                        ras_ptr <= ras_ptr + PTR_W'(1);
                        if (ras_cnt != CNT_MAX)
                            ras_cnt <= ras_cnt + CNT_W'(1);
                    end
                end
                3'd5: begin
                    // Underflow takes precedence: an empty stack has no target to check.
                    if (ras_cnt == '0) begin
                        pc_out        <= TRAP_VEC;
                        epc           <= pc_out;
                        ras_underflow <= 1'b1;
                    end else if (top_bad) begin
                        pc_out   <= TRAP_VEC;
                        epc      <= pc_out;
                        misalign <= 1'b1;
                    end else begin
                        pc_out  <= ras_top;
                        ras_ptr <= ras_ptr_m1;
                        ras_cnt <= ras_cnt - CNT_W'(1);
                    end
                end
                3'd6: begin
                    pc_out <= TRAP_VEC;
                    epc    <= pc_out;
                end
                3'd7: begin
                    if (epc_bad) begin
                        pc_out   <= TRAP_VEC;
                        epc      <= pc_out;
                        misalign <= 1'b1;
                    end else begin
                        pc_out <= epc;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a behavioural model (RAS as a bounded LIFO queue) pushes expected
// state per driven cycle, and the DUT state is popped and compared after each edge.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic [31:0] jump_dir = '0;
    logic [31:0] pc_out, pc_inc, epc_out;
    logic        ras_empty, ras_full, misalign, ras_underflow;

    pc_gen dut (
        .clk(clk), .rst(rst), .stall(stall), .sel(sel), .jump_dir(jump_dir),
        .pc_out(pc_out), .pc_inc(pc_inc), .epc_out(epc_out),
        .ras_empty(ras_empty), .ras_full(ras_full),
        .misalign(misalign), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        empty;
        logic        full;
        logic        mis;
        logic        und;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_ras[$];
    logic [31:0] m_pc, m_epc;
    logic        m_mis, m_und;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic unaligned(input logic [31:0] a);
        return a[1:0] != 2'b00;
    endfunction

    task automatic m_trap(input logic is_mis);
        m_epc = m_pc;
        m_pc  = 32'h100;
        if (is_mis) m_mis = 1'b1;
        else        m_und = 1'b1;
    endtask

    task automatic model(input logic r, input logic s, input logic [2:0] sl, input logic [31:0] jd);
        m_mis = 1'b0;
        m_und = 1'b0;
        if (r) begin
            m_pc  = 32'h0;
            m_epc = 32'h0;
            m_ras.delete();
        end else if (!s) begin
            case (sl)
                3'd0: m_pc = 32'h0;
                3'd1: if (unaligned(jd)) m_trap(1'b1); else m_pc = jd;
                3'd2: m_pc = m_pc + 32'd4;
                3'd3: ;
                3'd4: begin
                    if (unaligned(jd)) m_trap(1'b1);
                    else begin
                        m_ras.push_back(m_pc + 32'd4);
                        if (m_ras.size() > 4) void'(m_ras.pop_front());
                        m_pc = jd;
                    end
                end
                3'd5: begin
                    if (m_ras.size() == 0) m_trap(1'b0);
                    else if (unaligned(m_ras[$])) m_trap(1'b1);
                    else m_pc = m_ras.pop_back();
                end
                3'd6: begin
                    m_epc = m_pc;
                    m_pc  = 32'h100;
                end
                3'd7: if (unaligned(m_epc)) m_trap(1'b1); else m_pc = m_epc;
            endcase
        end
        sb.push_back('{m_pc, m_epc, m_ras.size() == 0, m_ras.size() == 4, m_mis, m_und});
    endtask

    task automatic step(input logic r, input logic s, input logic [2:0] sl, input logic [31:0] jd);
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; sel = sl; jump_dir = jd;
        model(r, s, sl, jd);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("pc", pc_out, e.pc);
            chk("pc_inc", pc_inc, e.pc + 32'd4);
            chk("epc", epc_out, e.epc);
            chk("empty", 32'(ras_empty), 32'(e.empty));
            chk("full", 32'(ras_full), 32'(e.full));
            chk("misalign", 32'(misalign), 32'(e.mis));
            chk("underflow", 32'(ras_underflow), 32'(e.und));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        // reset and sequential fetch
        step(1, 0, 3'd0, 0);
        step(1, 0, 3'd0, 0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_epc", epc_out, 32'h0);
        chk("rst_empty", 32'(ras_empty), 32'd1);
        step(0, 0, 3'd2, 0); chk("seq1", pc_out, 32'h4);
        step(0, 0, 3'd2, 0); chk("seq2", pc_out, 32'h8);
        step(0, 0, 3'd2, 0); chk("seq3", pc_out, 32'hC);
        chk("seq_inc", pc_inc, 32'h10);

        // call/return nest from pc=8
        step(0, 0, 3'd1, 32'h8);
        step(0, 0, 3'd4, 32'h40); chk("call1", pc_out, 32'h40);
        step(0, 0, 3'd4, 32'h80); chk("call2", pc_out, 32'h80);
        step(0, 0, 3'd5, 0);      chk("ret1", pc_out, 32'h44);
        step(0, 0, 3'd5, 0);      chk("ret2", pc_out, 32'hC);
        chk("nest_empty", 32'(ras_empty), 32'd1);

        // overflow: oldest link 'h10 is overwritten
        for (int i = 2; i <= 6; i++) step(0, 0, 3'd4, 32'(i) << 8);
        chk("ovf_full", 32'(ras_full), 32'd1);
        step(0, 0, 3'd5, 0); chk("lifo1", pc_out, 32'h504);
        step(0, 0, 3'd5, 0); chk("lifo2", pc_out, 32'h404);
        step(0, 0, 3'd5, 0); chk("lifo3", pc_out, 32'h304);
        step(0, 0, 3'd5, 0); chk("lifo4", pc_out, 32'h204);
        step(0, 0, 3'd5, 0);
        chk("und_pc", pc_out, 32'h100);
        chk("und_pulse", 32'(ras_underflow), 32'd1);
        chk("und_epc", epc_out, 32'h204);
        step(0, 0, 3'd3, 0); chk("und_clear", 32'(ras_underflow), 32'd0);

        // misalign on jump, trap-return, misaligned call, plain trap, sel=0
        step(0, 0, 3'd1, 32'h20);
        step(0, 0, 3'd1, 32'h42);
        chk("mis_pc", pc_out, 32'h100);
        chk("mis_pulse", 32'(misalign), 32'd1);
        chk("mis_epc", epc_out, 32'h20);
        step(0, 0, 3'd3, 0); chk("mis_clear", 32'(misalign), 32'd0);
        step(0, 0, 3'd7, 0); chk("eret", pc_out, 32'h20);
        step(0, 0, 3'd4, 32'h46);
        chk("mis_call_empty", 32'(ras_empty), 32'd1);
        step(0, 0, 3'd7, 0);
        step(0, 0, 3'd6, 0);
        chk("trap_epc", epc_out, 32'h20);
        step(0, 0, 3'd0, 0);

        // stall: held call, pulse cleared on a stalled edge
        step(0, 0, 3'd1, 32'h30);
        step(0, 1, 3'd4, 32'h60); chk("stall_pc", pc_out, 32'h30);
        step(0, 0, 3'd4, 32'h60); chk("stall_done", pc_out, 32'h60);
        step(0, 0, 3'd1, 32'h61);
        step(0, 1, 3'd5, 0);      chk("stall_pulse", 32'(misalign), 32'd0);
        step(0, 0, 3'd5, 0);      chk("stall_ret", pc_out, 32'h34);

        // wrap and reset mid-call
        step(0, 0, 3'd1, 32'hFFFF_FFFC);
        chk("wrap_inc", pc_inc, 32'h0);
        step(0, 0, 3'd2, 0); chk("wrap_pc", pc_out, 32'h0);
        step(0, 0, 3'd4, 32'h80);
        step(1, 1, 3'd4, 32'h90);
        chk("rst_mid_pc", pc_out, 32'h0);
        chk("rst_mid_empty", 32'(ras_empty), 32'd1);
        step(0, 0, 3'd5, 0); chk("rst_no_push", 32'(ras_underflow), 32'd1);

        // random mix against the model
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
                 3'($urandom_range(0, 7)), {$urandom_range(0, 255), ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
